// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the AES round scheduler: FSM states, round kinds,
// key_size codes and the key_size -> round count mapping.
package aes_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    KX_PULSE_S = 3'd1,
    KX_WAIT    = 3'd2,
    ROUNDS     = 3'd3,
    DONE       = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RK_INIT  = 2'd0,
    RK_FULL  = 2'd1,
    RK_FINAL = 2'd2
  } round_kind_e;

  localparam logic [2:0] KS_128 = 3'b001;
  localparam logic [2:0] KS_192 = 3'b010;
  localparam logic [2:0] KS_256 = 3'b100;

  localparam int KEY_W  = 256;
  localparam int RK_W   = 128;
  localparam int MAX_NR = 14;
  localparam int EXP_W  = RK_W * (MAX_NR + 1);

  // Any code other than the 192/256 encodings is treated as AES-128.
  function automatic logic [3:0] nr_of(input logic [2:0] ks);
    case (ks)
      KS_192:  return 4'd12;
      KS_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic round_kind_e kind_of(input logic [3:0] idx, input logic [3:0] nr);
    if (idx == 4'd0) begin
      return RK_INIT;
    end else if (idx == nr) begin
      return RK_FINAL;
    end else begin
      return RK_FULL;
    end
  endfunction

endpackage

// File: rtl/aes_round_key_mux.sv
// Combinational round-key select: picks the 128-bit slice of the expanded key for round sel.
// Round r sits MSB-first at vector bits [EXP_W-1-128r -: 128]; sel values above MAX_NR give zero.
module aes_round_key_mux
  import aes_sched_pkg::*;
(
  input  logic [EXP_W-1:0] kx_exp,
  input  logic [3:0]       sel,
  output logic [RK_W-1:0]  round_key
);

  always_comb begin
    round_key = '0;
    for (int r = 0; r <= MAX_NR; r++) begin
      if (sel == 4'(r)) begin
        round_key = kx_exp[EXP_W-1-RK_W*r -: RK_W];
      end
    end
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// Sequences one AES block: start accept, key-expansion pulse and settle, then rounds 0..Nr
// over a valid/ready handshake. Optional AES_KEY_CACHE_EN skips expansion for a repeated key.
module aes_round_scheduler
  import aes_sched_pkg::*;
#(
  parameter int KX_PULSE  = 1,
  parameter int KX_SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [2:0]        key_size,
  input  logic [KEY_W-1:0]  key,
  output logic              kx_en,
  output logic [KEY_W-1:0]  kx_key,
  output logic [2:0]        kx_size,
  input  logic [EXP_W-1:0]  kx_exp,
  output logic              round_valid,
  input  logic              round_ready,
  output logic [3:0]        round_idx,
  output logic [1:0]        round_kind,
  output logic [RK_W-1:0]   round_key,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         nr_q, nr_d;
  logic [3:0]         idx_q, idx_d;
  round_kind_e        kind_q, kind_d;
  logic [RK_W-1:0]    rkey_q, rkey_d;
  logic [KEY_W-1:0]   kx_key_q, kx_key_d;
  logic [2:0]         kx_size_q, kx_size_d;

  logic               accept;
  logic               hs;
  logic               last_round;
  logic               enter_rounds;
  logic               advance;
  logic               cache_hit;
  logic [3:0]         key_sel;
  logic [RK_W-1:0]    mux_key;

  assign accept       = start_valid && (state_q == IDLE);
  assign hs           = (state_q == ROUNDS) && round_ready;
  assign last_round   = (idx_q == nr_q);
  assign enter_rounds = (state_d == ROUNDS) && (state_q != ROUNDS);
  assign advance      = hs && !last_round;
  assign key_sel      = enter_rounds ? 4'd0 : idx_q + 4'd1;

  aes_round_key_mux u_key_mux (
    .kx_exp    (kx_exp),
    .sel       (key_sel),
    .round_key (mux_key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept) state_d = cache_hit ? ROUNDS : KX_PULSE_S;
      KX_PULSE_S: if (cnt_q == 4'(KX_PULSE - 1)) state_d = KX_WAIT;
      KX_WAIT:    if (cnt_q == 4'(KX_SETTLE - 1)) state_d = ROUNDS;
      ROUNDS:     if (hs && last_round) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    kx_en       = 1'b0;
    round_valid = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      KX_PULSE_S: kx_en       = 1'b1;
      ROUNDS:     round_valid = 1'b1;
      DONE:       done        = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    nr_d      = nr_q;
    kx_key_d  = kx_key_q;
    kx_size_d = kx_size_q;
    idx_d     = idx_q;
    kind_d    = kind_q;
    rkey_d    = rkey_q;

    // Phase counter restarts on every state change and only runs in the expansion states.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == KX_PULSE_S || state_q == KX_WAIT) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (accept) begin
      kx_key_d  = key;
      kx_size_d = key_size;
      nr_d      = nr_of(key_size);
    end

    if (enter_rounds) begin
      idx_d  = 4'd0;
      kind_d = RK_INIT;
      rkey_d = mux_key;
    end else if (advance) begin
      idx_d  = key_sel;
      kind_d = kind_of(key_sel, nr_q);
      rkey_d = mux_key;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      nr_q      <= '0;
      kx_key_q  <= '0;
      kx_size_q <= '0;
      idx_q     <= '0;
      kind_q    <= RK_INIT;
      rkey_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      nr_q      <= nr_d;
      kx_key_q  <= kx_key_d;
      kx_size_q <= kx_size_d;
      idx_q     <= idx_d;
      kind_q    <= kind_d;
      rkey_q    <= rkey_d;
    end
  end

`ifdef AES_KEY_CACHE_EN
  logic [KEY_W-1:0] cache_key_q, cache_key_d;
  logic [2:0]       cache_size_q, cache_size_d;
  logic             cache_vld_q, cache_vld_d;

  // The expander still holds the previous expansion, so an identical request can go straight to rounds.
  assign cache_hit = cache_vld_q && (key == cache_key_q) && (key_size == cache_size_q);

  always_comb begin
    cache_key_d  = cache_key_q;
    cache_size_d = cache_size_q;
    cache_vld_d  = cache_vld_q;
    if (enter_rounds) begin
      cache_key_d  = kx_key_d;
      cache_size_d = kx_size_d;
      cache_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_key_q  <= '0;
      cache_size_q <= '0;
      cache_vld_q  <= 1'b0;
    end else begin
      cache_key_q  <= cache_key_d;
      cache_size_q <= cache_size_d;
      cache_vld_q  <= cache_vld_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  assign kx_key     = kx_key_q;
  assign kx_size    = kx_size_q;
  assign round_idx  = idx_q;
  assign round_kind = kind_q;
  assign round_key  = rkey_q;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed bench for aes_round_scheduler: drives a stand-in expanded key built from FIPS-197
// round keys (unlisted rounds use marker patterns) and checks handshake sequencing and timing.
module tb_aes_round_scheduler;

`ifdef AES_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [2:0]    key_size;
  logic [255:0]  key;
  logic          kx_en;
  logic [255:0]  kx_key;
  logic [2:0]    kx_size;
  logic [1919:0] kx_exp;
  logic          round_valid;
  logic          round_ready;
  logic [3:0]    round_idx;
  logic [1:0]    round_kind;
  logic [127:0]  round_key;
  logic          busy;
  logic          done;

  logic [127:0]  rk [0:14];
  int            errors = 0;
  int            checks = 0;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K128B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_round_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .key_size    (key_size),
    .key         (key),
    .kx_en       (kx_en),
    .kx_key      (kx_key),
    .kx_size     (kx_size),
    .kx_exp      (kx_exp),
    .round_valid (round_valid),
    .round_ready (round_ready),
    .round_idx   (round_idx),
    .round_kind  (round_kind),
    .round_key   (round_key),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rounds without a published value carry a per-round marker so a wrong slice is visible.
  task automatic set_rk(input logic [127:0] r0, input logic [127:0] rfin, input int nr);
    for (int r = 0; r <= 14; r++) begin
      logic [7:0] b;
      b = 8'(r);
      rk[r] = {8{b, 8'h5a}};
    end
    rk[0]  = r0;
    rk[nr] = rfin;
    for (int r = 0; r <= 14; r++) begin
      kx_exp[1919-128*r -: 128] = rk[r];
    end
  endtask

  task automatic run_op(input logic [255:0] k, input logic [2:0] ks, input int nr,
                        input bit exp_kx, input int stall_r);
    @(negedge clk);
    key = k; key_size = ks; start_valid = 1'b1;
    chk("start_ready_idle", start_ready, 1);
    @(negedge clk);
    start_valid = 1'b0; key = ~k; key_size = ~ks;
    chk("kx_key", kx_key, k);
    chk("kx_size", kx_size, ks);
    chk("busy_c1", busy, 1);
    if (exp_kx) begin
      chk("kx_en_c1", kx_en, 1);
      chk("valid_c1", round_valid, 0);
      @(negedge clk);
      chk("kx_en_c2", kx_en, 0);
      @(negedge clk);
      chk("valid_c3", round_valid, 0);
      @(negedge clk);
    end else begin
      chk("kx_en_hit", kx_en, 0);
    end
    for (int r = 0; r <= nr; r++) begin
      chk("round_valid", round_valid, 1);
      chk("round_idx", round_idx, r);
      chk("round_kind", round_kind, (r == 0) ? 0 : ((r == nr) ? 2 : 1));
      chk("round_key", round_key, rk[r]);
      if (r == stall_r) begin
        for (int s = 0; s < 5; s++) begin
          start_valid = 1'b1;
          @(negedge clk);
          chk("stall_valid", round_valid, 1);
          chk("stall_idx", round_idx, r);
          chk("stall_key", round_key, rk[r]);
          chk("stall_kind", round_kind, 1);
          chk("stall_kx_en", kx_en, 0);
        end
        start_valid = 1'b0;
        chk("kx_key_held", kx_key, k);
      end
      round_ready = 1'b1;
      @(negedge clk);
      round_ready = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_valid", round_valid, 0);
    chk("done_busy", busy, 1);
    chk("done_start_ready", start_ready, 0);
    start_valid = 1'b1; key = k; key_size = ks;
    @(negedge clk);
    start_valid = 1'b0;
    chk("done_drop", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_start_ready", start_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    key_size = 3'b000;
    key = '0;
    round_ready = 1'b0;
    kx_exp = '0;

    repeat (2) @(negedge clk);
    chk("rst_kx_en", kx_en, 0);
    chk("rst_valid", round_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", round_idx, 0);
    chk("rst_kind", round_kind, 0);
    chk("rst_key", round_key, 0);
    chk("rst_kx_key", kx_key, 0);
    chk("rst_kx_size", kx_size, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_start_ready", start_ready, 1);

    set_rk(K128[255:128], 128'h13111d7fe3944a17f307a78b4d2b30c5, 10);
    run_op(K128, 3'b001, 10, 1'b1, -1);

    set_rk(K192[255:128], 128'ha4970a331a78dc09c418c271e3a41d5d, 12);
    run_op(K192, 3'b010, 12, 1'b1, 3);

    set_rk(K256[255:128], 128'h24fc79ccbf0979e9371ac23c6d68de36, 14);
    rk[1] = K256[127:0];
    kx_exp[1919-128 -: 128] = rk[1];
    run_op(K256, 3'b100, 14, 1'b1, -1);

    // Abort at round 5 with an asynchronous reset.
    set_rk(K128[255:128], 128'h13111d7fe3944a17f307a78b4d2b30c5, 10);
    @(negedge clk);
    key = K128; key_size = 3'b001; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    round_ready = 1'b1;
    repeat (5) @(negedge clk);
    round_ready = 1'b0;
    chk("pre_abort_idx", round_idx, 5);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", round_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_kx_en", kx_en, 0);
    chk("abort_done", done, 0);
    chk("abort_idx", round_idx, 0);
    chk("abort_key", round_key, 0);
    chk("abort_kind", round_kind, 0);
    chk("abort_kx_key", kx_key, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_abort_done", done, 0);
      chk("post_abort_busy", busy, 0);
    end
    run_op(K128, 3'b001, 10, 1'b1, -1);

    // Same key again: skips expansion only when the cache is built in.
    run_op(K128, 3'b001, 10, !CACHE_ON, -1);

    set_rk(K128B[255:128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 10);
    run_op(K128B, 3'b001, 10, 1'b1, -1);

    // Unsupported size code: AES-128 round count, code passed through.
    run_op(K128B, 3'b111, 10, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
